alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 3-bit ALU control code and the ALU-source-selected operands produced by instruction decode.
- Computes the result plus comparison flags; the flags serve SLT/SLTU writeback and branch resolution, since decode maps those to SUB.
- Sits between decode/operand-mux and writeback, with valid/ready handshakes on both sides.
- Shifts are iterative, one bit per cycle, unless the fast-shift option is compiled in.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; shift amount = op_b[SHAMT_W-1:0], upper bits ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- aluctrl  input  3  control code; uses the ADD, SUB, SLL, SRL, SRA, XOR, OR, AND macros from the shared macro header; all 8 encodings are legal.
- op_a  input  WIDTH  first operand (rs1 or PC).
- op_b  input  WIDTH  second operand (rs2 or immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- lt_signed  output  1  signed(op_a) < signed(op_b), from captured operands.
- lt_unsigned  output  1  op_a < op_b unsigned, from captured operands (subtract borrow).

Behaviour:
- States:
  - IDLE: in_ready=1.
  - SHIFT: iterating.
  - DONE: out_valid=1.
- Reset (rst=1 at a clock edge):
  - state=IDLE; result=0, zero=0, lt_signed=0, lt_unsigned=0, out_valid=0, in_ready=1 on the following cycle.
  - Reset overrides any in-flight operation; a partial shift is discarded and no output is produced.
- Accept:
  - Occurs when in_valid && in_ready at an edge.
  - aluctrl, op_a, op_b are captured.
  - Flags lt_signed and lt_unsigned are computed from the captured operands.
- Non-shift codes (ADD, SUB, XOR, OR, AND):
  - Result is computed at the accept edge and the unit goes to DONE.
  - out_valid is high the cycle after accept (latency 1).
  - ADD/SUB wrap modulo 2^WIDTH; no overflow output.
- Shift codes (SLL, SRL, SRA):
  - shamt=0: go directly to DONE with result=op_a (latency 1).
  - Otherwise go to SHIFT with working register=op_a and counter=shamt.
  - Each SHIFT cycle shifts by 1 and decrements the counter:
    - SLL shifts in 0 at the LSB.
    - SRL shifts in 0 at the MSB.
    - SRA replicates the MSB.
  - Counter reaching 0 transitions to DONE.
  - Total latency = 1 + shamt cycles from accept to out_valid; maximum 32.
- DONE:
  - result, zero, and both lt flags are held stable while out_valid && !out_ready.
  - out_valid && out_ready at an edge returns the unit to IDLE.
  - No accept occurs in the same cycle as the output handshake; in_ready is low in DONE, so back-to-back throughput is one op per 2 cycles minimum.
- zero reflects the final result and is updated when entering DONE.
- in_valid while busy is ignored; upstream must hold.
- Operand inputs may change freely after accept without affecting the in-flight op.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined:
  - Shifts use a single-cycle barrel shifter; all codes complete with latency 1.
  - The SHIFT state and counter are not synthesized.
- Undefined:
  - Iterative shifter as specified above; latency 1 + shamt.
- Results, flags, and handshake rules are identical in both builds; only latency differs.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst 2 cycles.
  - Required: in_ready=1, out_valid=0, result=0 after release.
- ADD wrap:
  - Stimulus: op_a=0xFFFFFFFF, op_b=0x00000001.
  - Required: one cycle later out_valid=1, result=0x00000000, zero=1, lt_signed=1, lt_unsigned=0.
- SUB for SLT/branch:
  - Stimulus: op_a=0x80000000, op_b=0x00000001.
  - Required: result=0x7FFFFFFF, lt_signed=1, lt_unsigned=0, zero=0.
- SRA iterative:
  - Stimulus: op_a=0xF0000000, op_b=0x00000004.
  - Required: out_valid rises exactly 5 cycles after accept, result=0xFF000000; with ALU_FAST_SHIFT_EN, 1 cycle.
- Output backpressure:
  - Stimulus: XOR op_a=0x0F0F0F0F, op_b=0xFFFF0000 with out_ready=0 for 4 cycles; in_valid held with a new op.
  - Required: result=0xF0F00F0F stable, in_ready=0 throughout; new op is accepted only after the out_ready handshake.
- Reset mid-shift:
  - Stimulus: SLL op_a=1, op_b=31; assert rst on the 10th SHIFT cycle.
  - Required: next cycle IDLE, out_valid=0, result=0; no spurious output afterwards.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Handshake/operand bus between decode/operand-mux (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       aluctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             lt_signed;
    logic             lt_unsigned;

    modport master (
        output in_valid, aluctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, lt_signed, lt_unsigned
    );

    modport slave (
        input  in_valid, aluctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, lt_signed, lt_unsigned
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: result plus signed/unsigned compare flags.
// Shifts iterate one bit per cycle; define ALU_FAST_SHIFT_EN for a
// single-cycle barrel shifter (no SHIFT state, no counter).
// Control codes come from the shared macro header; defaults below apply
// only when that header has not been included.
`ifndef ADD
`define ADD 3'b000
`endif
`ifndef SUB
`define SUB 3'b001
`endif
`ifndef SLL
`define SLL 3'b010
`endif
`ifndef SRL
`define SRL 3'b011
`endif
`ifndef SRA
`define SRA 3'b100
`endif
`ifndef XOR
`define XOR 3'b101
`endif
`ifndef OR
`define OR  3'b110
`endif
`ifndef AND
`define AND 3'b111
`endif

module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_lt_s;
    logic               r_lt_u;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_imm_result;
`ifndef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_shift_next;
`endif

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_shamt  = bus.op_b[SHAMT_W-1:0];
    // Extra MSB of the widened subtraction is the unsigned borrow.
    assign w_diff   = {1'b0, bus.op_a} - {1'b0, bus.op_b};

    // Result available at the accept edge (shifts seed with op_a unless barrel build)
    always_comb begin
        w_imm_result = bus.op_a;
        case (bus.aluctrl)
            `ADD: w_imm_result = bus.op_a + bus.op_b;
            `SUB: w_imm_result = w_diff[WIDTH-1:0];
            `XOR: w_imm_result = bus.op_a ^ bus.op_b;
            `OR:  w_imm_result = bus.op_a | bus.op_b;
            `AND: w_imm_result = bus.op_a & bus.op_b;
`ifdef ALU_FAST_SHIFT_EN
            `SLL: w_imm_result = bus.op_a << w_shamt;
            `SRL: w_imm_result = bus.op_a >> w_shamt;
            `SRA: w_imm_result = $signed(bus.op_a) >>> w_shamt;
`endif
            default: w_imm_result = bus.op_a;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    assign w_is_shift = (bus.aluctrl == `SLL) || (bus.aluctrl == `SRL) || (bus.aluctrl == `SRA);

    // One-bit step of the iterative shifter
    always_comb begin
        w_shift_next = r_result;
        case (r_op)
            `SLL:    w_shift_next = {r_result[WIDTH-2:0], 1'b0};
            `SRL:    w_shift_next = {1'b0, r_result[WIDTH-1:1]};
            default: w_shift_next = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        endcase
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (w_is_shift && (w_shamt != '0)) w_state_next = S_SHIFT;
                    else                               w_state_next = S_DONE;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            S_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_next = S_DONE;
`endif
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture at accept, iterate in SHIFT, hold in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_lt_s   <= 1'b0;
            r_lt_u   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            r_cnt    <= '0;
            r_op     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lt_s   <= $signed(bus.op_a) < $signed(bus.op_b);
                        r_lt_u   <= w_diff[WIDTH];
                        r_result <= w_imm_result;
`ifndef ALU_FAST_SHIFT_EN
                        r_op     <= bus.aluctrl;
                        r_cnt    <= w_shamt;
                        // zero is only refreshed on the transition into DONE
                        if (!(w_is_shift && (w_shamt != '0)))
                            r_zero <= (w_imm_result == '0);
`else
                        r_zero   <= (w_imm_result == '0);
`endif
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                S_SHIFT: begin
                    r_result <= w_shift_next;
                    r_cnt    <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) r_zero <= (w_shift_next == '0);
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and registered datapath
    always_comb begin
        bus.in_ready    = (r_state == S_IDLE);
        bus.out_valid   = (r_state == S_DONE);
        bus.result      = r_result;
        bus.zero        = r_zero;
        bus.lt_signed   = r_lt_s;
        bus.lt_unsigned = r_lt_u;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit (either shifter build).
module tb_alu_exec_unit;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_SLL = 3'b010;
    localparam logic [2:0] C_SRL = 3'b011;
    localparam logic [2:0] C_SRA = 3'b100;
    localparam logic [2:0] C_XOR = 3'b101;
    localparam logic [2:0] C_OR  = 3'b110;
    localparam logic [2:0] C_AND = 3'b111;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        lts;
        logic        ltu;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        int          sh;
        sh = int'(b[4:0]);
        r  = a;
        case (c)
            C_ADD: r = a + b;
            C_SUB: r = a - b;
            C_XOR: r = a ^ b;
            C_OR:  r = a | b;
            C_AND: r = a & b;
            C_SLL: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            C_SRL: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
            default: for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
        endcase
        e.res = r;
        e.z   = (r == 32'd0);
        e.lts = ($signed(a) < $signed(b));
        e.ltu = (a < b);
`ifdef ALU_FAST_SHIFT_EN
        e.lat = 1;
`else
        e.lat = (c == C_SLL || c == C_SRL || c == C_SRA) ? 1 + sh : 1;
`endif
        return e;
    endfunction

    // Drive one op, wait for its result, compare against the scoreboard, then handshake out.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   w;
        sb.push_back(model(c, a, b));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluctrl  = c;
        bus.op_a     = a;
        bus.op_b     = b;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept_timeout"}, (w < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.aluctrl  = 3'($urandom_range(0, 7));
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_result"}, bus.result, e.res);
        check({tag, "_zero"}, 32'(bus.zero), 32'(e.z));
        check({tag, "_lt_signed"}, 32'(bus.lt_signed), 32'(e.lts));
        check({tag, "_lt_unsigned"}, 32'(bus.lt_unsigned), 32'(e.ltu));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    endtask

    initial begin
        exp_t e;
        int   w;
        int   spurious;
        bus.in_valid  = 1'b0;
        bus.aluctrl   = 3'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);

        run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        check("add_wrap_const", bus.result, 32'h0000_0000);
        run_op("sub_slt", C_SUB, 32'h8000_0000, 32'h0000_0001);
        check("sub_slt_const", bus.result, 32'h7FFF_FFFF);
        run_op("sra4", C_SRA, 32'hF000_0000, 32'h0000_0004);
        check("sra4_const", bus.result, 32'hFF00_0000);
        run_op("sll_upper_ign", C_SLL, 32'h0000_0003, 32'hFFFF_FFE5);
        run_op("srl31", C_SRL, 32'h8000_0000, 32'h0000_001F);
        run_op("sra_shamt0", C_SRA, 32'h8123_4567, 32'h0000_0020);
        run_op("sll_to_zero", C_SLL, 32'h8000_0000, 32'h0000_0001);
        run_op("or", C_OR, 32'h1234_0000, 32'h0000_5678);
        run_op("and", C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        run_op("sub_eq", C_SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Output backpressure with a second op held on the input side
        sb.push_back(model(C_XOR, 32'h0F0F_0F0F, 32'hFFFF_0000));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluctrl  = C_XOR;
        bus.op_a     = 32'h0F0F_0F0F;
        bus.op_b     = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(model(C_ADD, 32'h0000_0010, 32'h0000_0020));
        bus.aluctrl = C_ADD;
        bus.op_a    = 32'h0000_0010;
        bus.op_b    = 32'h0000_0020;
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.result, e.res);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_result_const", bus.result, 32'hF0F0_0F0F);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_no_same_cycle_accept", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_result", bus.result, e.res);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset on the 10th SHIFT cycle of a long SLL
        bus.in_valid = 1'b1;
        bus.aluctrl  = C_SLL;
        bus.op_a     = 32'h0000_0001;
        bus.op_b     = 32'd31;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) spurious++;
            @(negedge clk);
        end
        check("midrst_spurious", 32'(spurious), 32'd0);

        run_op("post_rst_xor", C_XOR, 32'hAAAA_5555, 32'h5555_AAAA);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
